// File: rtl/crossbar_pkg.sv
// Shared definitions for the round-robin crossbar switch.
//   route_idx_t  : route index wide enough for the largest legal port count
//   data_word_t  : payload word at the default data width
//   sat_inc()    : saturating increment for counters up to 32 bits wide
package crossbar_pkg;

  localparam int MAX_PORTS      = 32;
  localparam int MAX_ROUTE_BITS = $clog2(MAX_PORTS);
  localparam int DEFAULT_W      = 8;

  // Route fields narrower than this are zero-extended before comparison,
  // so one type serves every legal port count.
  typedef logic [MAX_ROUTE_BITS-1:0] route_idx_t;
  typedef logic [DEFAULT_W-1:0]      data_word_t;

  // Increment value, holding at 2^width-1. Widths above 32 are not supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value >= max_val) ? max_val : value + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one crossbar output.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : N request lines
//   advance    : commit this cycle's grant (moves the pointer past the winner)
//   grant      : one-hot grant, zero when no request
//   grant_idx  : index of the granted request
//   any_grant  : a grant is present
//   multi_req  : two or more requests are present (contention)
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant,
  output logic                 multi_req
);

  localparam int IDXW = $clog2(N);

  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] idx;

  // Search from ptr upward; the modulo wraps N-1 back to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDXW'((int'(ptr) + k) % N);
      if (!any_grant && req[idx]) begin
        any_grant      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign multi_req = ((req & (req - N'(1))) != '0);

  // N is a power of two, so the +1 wraps to 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && any_grant) begin
      ptr <= grant_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/crossbar_rr_switch.sv
// N x N crossbar with an independent round-robin arbiter per output.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid/in_data/in_route : per-input word and destination index
//   in_ready        : input granted this cycle (combinational); a word moves
//                     on in_valid & in_ready. No output backpressure exists.
//   output_enable   : output j may be granted; disabled outputs hold inputs waiting
//   out_valid/out_data : registered output word, data forced to 0 when not valid
//   collision       : registered flag, some output had >=2 requests last cycle
//   collision_count : saturating count of contention cycles
module crossbar_rr_switch
  import crossbar_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N-1:0]                   in_valid,
  input  logic [N-1:0][W-1:0]            in_data,
  input  logic [N-1:0][$clog2(N)-1:0]    in_route,
  output logic [N-1:0]                   in_ready,
  input  logic [N-1:0]                   output_enable,
  output logic [N-1:0]                   out_valid,
  output logic [N-1:0][W-1:0]            out_data,
  output logic                           collision,
  output logic [CW-1:0]                  collision_count
);

  localparam int ROUTE_BITS = $clog2(N);

  logic [N-1:0][N-1:0]          grant;     // [output][input]
  logic [N-1:0][ROUTE_BITS-1:0] grant_idx;
  logic [N-1:0]                 any_grant;
  logic [N-1:0]                 multi_req;
  logic                         contention;

  for (genvar j = 0; j < N; j++) begin : g_out
    logic [N-1:0] req;
    for (genvar i = 0; i < N; i++) begin : g_req
      assign req[i] = in_valid[i] && output_enable[j] &&
                      (route_idx_t'(in_route[i]) == route_idx_t'(j));
    end

    rr_arbiter #(.N(N)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .advance   (output_enable[j]),
      .grant     (grant[j]),
      .grant_idx (grant_idx[j]),
      .any_grant (any_grant[j]),
      .multi_req (multi_req[j])
    );
  end

  // Each input has one route, so at most one output can grant it.
  // Ready is held low during reset so nothing is consumed while outputs are cleared.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        in_ready[i] = in_ready[i] | grant[j][i];
      end
    end
    in_ready = in_ready & {N{rst_n}};
  end

  assign contention = |multi_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid       <= '0;
      out_data        <= '0;
      collision       <= 1'b0;
      collision_count <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        out_valid[j] <= any_grant[j];
        out_data[j]  <= any_grant[j] ? in_data[grant_idx[j]] : '0;
      end
      collision <= contention;
      if (contention) begin
        collision_count <= CW'(sat_inc(32'(collision_count), CW));
      end
    end
  end

endmodule

// File: tb/tb_crossbar_rr_switch.sv
module tb_crossbar_rr_switch;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]       in_valid, in_ready, output_enable, out_valid;
  logic [3:0][7:0]  in_data, out_data;
  logic [3:0][1:0]  in_route;
  logic             collision;
  logic [15:0]      collision_count;
  logic [3:0]       in_ready_b, out_valid_b;
  logic [3:0][7:0]  out_data_b;
  logic             collision_b;
  logic [1:0]       collision_count_b;

  crossbar_rr_switch #(.N(4), .W(8), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_route(in_route), .in_ready(in_ready), .output_enable(output_enable),
    .out_valid(out_valid), .out_data(out_data), .collision(collision),
    .collision_count(collision_count)
  );

  // Same stimulus, 2-bit counter to exercise saturation.
  crossbar_rr_switch #(.N(4), .W(8), .CW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_route(in_route), .in_ready(in_ready_b), .output_enable(output_enable),
    .out_valid(out_valid_b), .out_data(out_data_b), .collision(collision_b),
    .collision_count(collision_count_b)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_ptr[4];
  logic [3:0] m_ov;
  logic [3:0][7:0] m_od;
  logic       m_coll;
  int         m_cnt, m_cnt_b;
  logic [3:0] seen_rdy;

  task automatic model_reset();
    for (int j = 0; j < 4; j++) m_ptr[j] = 0;
    m_ov = '0; m_od = '0; m_coll = 1'b0; m_cnt = 0; m_cnt_b = 0;
  endtask

  // Called at posedge+1 with inputs already driven; checks ready mid-cycle and
  // registered outputs after the next rising edge.
  task automatic step(input string tag);
    logic [3:0] exp_rdy, nv;
    logic [3:0][7:0] nd;
    bit cont;
    int nreq, g, i;
    exp_rdy = '0; nv = '0; nd = '0; cont = 0;
    for (int j = 0; j < 4; j++) begin
      nreq = 0; g = -1;
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr[j] + k) % 4;
        if (in_valid[i] && int'(in_route[i]) == j && output_enable[j]) begin
          nreq++;
          if (g < 0) g = i;
        end
      end
      if (nreq >= 2) cont = 1;
      if (g >= 0) begin
        exp_rdy[g] = 1'b1; nv[j] = 1'b1; nd[j] = in_data[g];
        m_ptr[j] = (g + 1) % 4;
      end
    end
    @(negedge clk);
    seen_rdy = in_ready;
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk); #1;
    m_ov = nv; m_od = nd; m_coll = cont;
    if (cont) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".out_data"}, 64'(out_data), 64'(m_od));
    chk({tag, ".collision"}, 64'(collision), 64'(m_coll));
    chk({tag, ".count"}, 64'(collision_count), 64'(m_cnt));
    chk({tag, ".count_b"}, 64'(collision_count_b), 64'(m_cnt_b));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'h0);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, ".out_data"}, 64'(out_data), 64'h0);
    chk({tag, ".collision"}, 64'(collision), 64'h0);
    chk({tag, ".count"}, 64'(collision_count), 64'h0);
    chk({tag, ".count_b"}, 64'(collision_count_b), 64'h0);
  endtask

  task automatic idle_inputs();
    in_valid = '0; in_data = '0; in_route = '0; output_enable = '1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]      valid;
    logic [3:0][7:0] data;
    logic [3:0][1:0] route;
    logic [3:0]      en;
    logic [3:0]      exp_rdy;
    logic [3:0]      exp_ov;
    logic [3:0][7:0] exp_od;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // single word in0=A5 -> out2
    tbl[0] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'hA5}, {2'd0, 2'd0, 2'd0, 2'd2}, 4'b1111,
               4'b0001, 4'b0100, {8'h00, 8'hA5, 8'h00, 8'h00}};
    // full permutation 0->3 1->2 2->1 3->0
    tbl[1] = '{4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, {2'd0, 2'd1, 2'd2, 2'd3}, 4'b1111,
               4'b1111, 4'b1111, {8'h11, 8'h22, 8'h33, 8'h44}};
    // identity with outputs 1 and 3 disabled
    tbl[2] = '{4'b1111, {8'h53, 8'h52, 8'h51, 8'h50}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0101,
               4'b0101, 4'b0101, {8'h00, 8'h52, 8'h00, 8'h50}};
    // nothing valid, junk routes/data ignored
    tbl[3] = '{4'b0000, {8'hFF, 8'hEE, 8'hDD, 8'hCC}, {2'd1, 2'd1, 2'd1, 2'd1}, 4'b1111,
               4'b0000, 4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}};
    // in1 -> out0, in3 -> out3
    tbl[4] = '{4'b1010, {8'h77, 8'h00, 8'h66, 8'h00}, {2'd3, 2'd0, 2'd0, 2'd0}, 4'b1111,
               4'b1010, 4'b1001, {8'h77, 8'h00, 8'h00, 8'h66}};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [3:0] exp_rdy_k;
    int order[6];
    order = '{0, 1, 3, 0, 1, 3};
    idle_inputs();
    rst_n = 1'b0;
    #2;
    do_reset();

    // Table-driven vectors
    for (int v = 0; v < 5; v++) begin
      in_valid = tbl[v].valid; in_data = tbl[v].data;
      in_route = tbl[v].route; output_enable = tbl[v].en;
      step($sformatf("tbl%0d", v));
      chk($sformatf("tbl%0d.rdy_const", v), 64'(seen_rdy), 64'(tbl[v].exp_rdy));
      chk($sformatf("tbl%0d.ov_const", v), 64'(out_valid), 64'(tbl[v].exp_ov));
      chk($sformatf("tbl%0d.od_const", v), 64'(out_data), 64'(tbl[v].exp_od));
    end

    // Three-way contention on output 1, round-robin order and counters
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back(4'(1 << order[k]));
    in_valid = 4'b1011; output_enable = '1;
    in_route = {2'd1, 2'd1, 2'd1, 2'd1};
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 6; k++) begin
      step($sformatf("rr%0d", k));
      exp_rdy_k = exp_q.pop_front();
      chk($sformatf("rr%0d.order", k), 64'(seen_rdy), 64'(exp_rdy_k));
      chk($sformatf("rr%0d.collision", k), 64'(collision), 64'h1);
      chk($sformatf("rr%0d.count", k), 64'(collision_count), 64'(k + 1));
      chk($sformatf("rr%0d.count_b", k), 64'(collision_count_b), 64'((k + 1 > 3) ? 3 : k + 1));
    end
    in_valid = '0;
    step("rr_end");
    chk("rr_end.collision", 64'(collision), 64'h0);
    chk("rr_end.count_hold", 64'(collision_count), 64'd6);

    // Disabled output holds its requester without dropping the word
    in_valid = 4'b0100; in_route = {2'd0, 2'd3, 2'd0, 2'd0};
    in_data = {8'h00, 8'h3C, 8'h00, 8'h00}; output_enable = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      step($sformatf("oe%0d", k));
      chk($sformatf("oe%0d.ready2", k), 64'(seen_rdy[2]), 64'h0);
      chk($sformatf("oe%0d.ov3", k), 64'(out_valid[3]), 64'h0);
    end
    output_enable = 4'b1111;
    step("oe_on");
    chk("oe_on.ready2", 64'(seen_rdy[2]), 64'h1);
    chk("oe_on.ov3", 64'(out_valid[3]), 64'h1);
    chk("oe_on.od3", 64'(out_data[3]), 64'h3C);
    in_valid = '0;
    step("oe_after");
    chk("oe_after.ov3", 64'(out_valid[3]), 64'h0);
    chk("oe_after.od3", 64'(out_data[3]), 64'h0);

    // Permutation stream with reset pulsed mid-stream
    in_valid = '1; output_enable = '1;
    in_route = {2'd0, 2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
      step($sformatf("perm%0d", k));
    end
    for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst_a");
    @(posedge clk); #1;
    chk_zero("midrst_b");
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("postrst.out_valid", 64'(out_valid), 64'h0);
    chk("postrst.out_data", 64'(out_data), 64'h0);
    in_valid = '1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) in_data[i] = 8'($urandom);
      step($sformatf("perm_post%0d", k));
      chk($sformatf("perm_post%0d.all", k), 64'(out_valid), 64'hF);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 300; k++) begin
      in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        in_route[i] = 2'($urandom_range(0, 3));
        in_data[i]  = 8'($urandom);
        output_enable[i] = ($urandom_range(0, 3) != 0);
      end
      step($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/crossbar_rr_switch.md
CROSSBAR_RR_SWITCH -- requirements
Module: crossbar_rr_switch

Interface
REQ-001 SHALL have parameter N, default 8, meaning port count; legal values are powers of two, 2..32.
REQ-002 SHALL have parameter W, default 8, meaning data width in bits, >=1.
REQ-003 SHALL have parameter CW, default 16, meaning collision counter width in bits.
REQ-004 SHALL derive localparam ROUTE_BITS = $clog2(N).
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, [N]x1, input i presents a word.
REQ-008 SHALL have port in_data, input, [N]xW, input payload.
REQ-009 SHALL have port in_route, input, [N]xROUTE_BITS, destination output index.
REQ-010 SHALL have port in_ready, output, [N]x1, word accepted this cycle (combinational).
REQ-011 SHALL have port output_enable, input, [N]x1, output j may be granted.
REQ-012 SHALL have port out_valid, output, [N]x1, registered output word valid.
REQ-013 SHALL have port out_data, output, [N]xW, registered output payload.
REQ-014 SHALL have port collision, output, 1, registered pulse: contention occurred in the previous cycle.
REQ-015 SHALL have port collision_count, output, CW, saturating count of contention cycles.

Function
REQ-016 SHALL define request r[j][i] = in_valid[i] & (in_route[i]==j) & output_enable[j].
REQ-017 SHALL arbitrate each output j independently by round-robin over r[j][*], searching from ptr[j] upward with wrap at N-1 to 0.
REQ-018 SHALL assert in_ready[i] in the same cycle exactly when input i is granted; an input transfers on in_valid & in_ready.
REQ-019 SHALL grant at most one input per output and at most one output per input per cycle (implied by a single route per input).
REQ-020 SHALL, on a grant of input g to output j, set ptr[j] <= (g+1) mod N; ptr[j] SHALL hold when output j grants nothing.
REQ-021 SHALL register out_valid[j] <= grant present and out_data[j] <= granted in_data, 1-cycle latency.
REQ-022 SHALL drive out_data[j] = 0 whenever out_valid[j] = 0; no stale data is ever visible.
REQ-023 SHALL, when output_enable[j] = 0, issue no grant for j, hold ptr[j], and deassert in_ready for inputs routed to j; those inputs wait, and no data is dropped.
REQ-024 SHALL hold no backpressure from outputs; a registered word is presented for exactly one cycle.
REQ-025 SHALL define contention as any output j with two or more requests in a cycle; collision <= contention, registered.
REQ-026 SHALL increment collision_count by 1 per contention cycle, regardless of how many outputs contend, and saturate at 2^CW-1.
REQ-027 SHALL treat in_route, in_data and output_enable as don't-care for arbitration when in_valid[i] = 0.

Reset
REQ-028 SHALL, on rst_n low, asynchronously clear out_valid, out_data, collision, collision_count and every ptr[j] to 0; in_ready SHALL be 0 while rst_n is low.
REQ-029 SHALL discard any word in flight when reset asserts mid-operation; the first grant after release SHALL start from ptr = 0.

Structure
REQ-030 SHALL place the route index typedef, the data word typedef parameterised by W, and the counter saturation helper in shared package crossbar_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (N requests, one-hot grant, registered pointer, advance input), instantiated N times.

Verification (N=4, W=8)
REQ-032 SHALL drive in0 = 0xA5 routed to 2 with all outputs enabled -> in_ready[0] is high the same cycle; out_valid[2] = 1 and out_data[2] = 0xA5 the next cycle; all other outputs are 0.
REQ-033 SHALL hold inputs 0, 1 and 3 valid to output 1 for 6 cycles -> grant order is 0, 1, 3, 0, 1, 3; collision is high in cycles 2..7; collision_count = 6.
REQ-034 SHALL hold output_enable[3] = 0 with in2 = 0x3C routed to 3 for 4 cycles, then set it to 1 -> in_ready[2] = 0 throughout, out_valid[3] = 0; 0x3C appears on out_data[3] exactly once, one cycle after enable.
REQ-035 SHALL set CW = 2 and hold contention for 5 cycles -> collision_count reaches 3 and stays at 3.
REQ-036 SHALL run a permutation 0->3, 1->2, 2->1, 3->0 with reset pulsed low mid-stream -> all outputs are 0 during reset, and after release the outputs resume the permutation with no stale data.
